// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the iterative divider: FSM state encoding,
// default datapath width, and the quotient returned on divide-by-zero.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // All-ones quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational radix-2 restoring division iteration.
// Ports:
//   rem_in       partial remainder from the previous iteration (WIDTH+1 bits)
//   dividend_bit next dividend bit shifted into the remainder
//   divisor      divisor magnitude
//   rem_out      partial remainder after this iteration
//   q_bit        quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] divisor_ext;

  // The incoming remainder is always below the divisor, so its top bit is
  // zero and the shifted value cannot exceed 2*divisor-1. The subtracted
  // result therefore always fits back into WIDTH+1 bits.
  always_comb begin
    rem_shift   = {rem_in, dividend_bit};
    divisor_ext = (WIDTH+2)'(divisor);
    q_bit       = (rem_shift >= divisor_ext);
    if (q_bit) begin
      rem_out = (WIDTH+1)'(rem_shift - divisor_ext);
    end else begin
      rem_out = (WIDTH+1)'(rem_shift);
    end
  end

endmodule

// File: rtl/div_iter.sv
// div_iter
// Iterative radix-2 restoring divider for div.w / div.wu / mod.w / mod.wu.
// Takes one signed or unsigned divide per request and produces a quotient
// (truncated toward zero) and remainder (sign of the dividend) after a fixed
// WIDTH iterations, independent of operand values.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   div_valid    request present          div_ready  idle, can accept
//   div_signed   two's-complement operands when 1
//   x, y         dividend, divisor
//   cancel       abort any in-flight work (only reset has higher priority)
//   out_valid    result valid             out_ready  consumer accepts result
//   quotient     registered quotient      remainder  registered remainder
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{DIV_ZERO_Q[0]}};

  div_state_e state, state_next;

  // The dividend register doubles as the quotient register: each step shifts
  // the consumed dividend bit out of the top and the new quotient bit in at
  // the bottom, so after WIDTH steps it holds the full quotient magnitude.
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] count;
  logic             q_neg;
  logic             r_neg;
  logic             y_zero;
  logic [WIDTH-1:0] x_raw;

  logic             accept;
  logic             finish;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in       (rem),
    .dividend_bit (dq[WIDTH-1]),
    .divisor      (divisor_mag),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode. Cancel overrides everything, so it also
  // suppresses acceptance and the final result load.
  always_comb begin
    state_next = state;
    div_ready  = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      DIV_IDLE: begin
        div_ready = 1'b1;
        if (div_valid && !cancel) begin
          accept     = 1'b1;
          state_next = DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (count == LAST_STEP) begin
          finish     = !cancel;
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = DIV_IDLE;
        end
      end
      default: begin
        state_next = DIV_IDLE;
      end
    endcase
    if (cancel) begin
      state_next = DIV_IDLE;
    end
  end

  // Operand magnitudes and final sign correction. The most negative dividend
  // maps to itself under negation, which is exactly its unsigned magnitude,
  // so signed overflow falls out of the unsigned datapath without a special case.
  always_comb begin
    x_mag = (div_signed && x[WIDTH-1]) ? -x : x;
    y_mag = (div_signed && y[WIDTH-1]) ? -y : y;
    q_mag = {dq[WIDTH-2:0], step_q};
    r_mag = step_rem[WIDTH-1:0];
  end

  // Datapath registers: load on accept, iterate in CALC, publish the result
  // on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      dq          <= '0;
      divisor_mag <= '0;
      rem         <= '0;
      count       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      y_zero      <= 1'b0;
      x_raw       <= '0;
      quotient    <= '0;
      remainder   <= '0;
    end else if (accept) begin
      dq          <= x_mag;
      divisor_mag <= y_mag;
      rem         <= '0;
      count       <= '0;
      q_neg       <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
      r_neg       <= div_signed & x[WIDTH-1];
      y_zero      <= (y == '0);
      x_raw       <= x;
    end else if (state == DIV_CALC && !cancel) begin
      dq    <= q_mag;
      rem   <= step_rem;
      count <= count + CNT_W'(1);
      if (finish) begin
        if (y_zero) begin
          quotient  <= ZERO_Q;
          remainder <= x_raw;
        end else begin
          quotient  <= q_neg ? -q_mag : q_mag;
          remainder <= r_neg ? -r_mag : r_mag;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter
// Self-checking bench for div_iter: directed vectors push their expected
// quotient/remainder into a scoreboard queue; a separate monitor pops and
// compares on every result handshake and checks the request-to-result latency.
module tb_div_iter;
  import div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         div_valid = 1'b0;
  logic         div_ready;
  logic         div_signed = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         cancel = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   cycle_cnt = 0;
  logic prev_valid = 1'b0;

  div_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .cancel     (cancel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: latency on the first DONE cycle, values on the handshake cycle.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, expected 0", cycle_cnt);
      end else begin
        if (!prev_valid) checkOutput("latency", W'(cycle_cnt - sb[0].acc), W'(W));
        if (out_ready) begin
          checkOutput("quotient", quotient, sb[0].q);
          checkOutput("remainder", remainder, sb[0].r);
          void'(sb.pop_front());
        end
      end
    end
    prev_valid = out_valid && !reset;
  end

  task automatic applyStimulus(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic s,
                               input logic [W-1:0] eq, input logic [W-1:0] er);
    int waited = 0;
    @(negedge clk);
    while (!div_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!div_ready) begin
      tests++;
      failed++;
      $display("[TB] FAIL accept_timeout: got div_ready=0, expected 1");
      return;
    end
    x = xi;
    y = yi;
    div_signed = s;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    sb.push_back(exp_t'{q: eq, r: er, acc: cycle_cnt});
    checkOutput("busy_after_accept", W'(div_ready), W'(0));
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      tests++;
      failed++;
      $display("[TB] FAIL valid_timeout: got out_valid=0, expected 1");
    end
  endtask

  task automatic checkIdleCleared(input string tag);
    checkOutput({tag, "_ready"}, W'(div_ready), W'(1));
    checkOutput({tag, "_valid"}, W'(out_valid), W'(0));
    checkOutput({tag, "_q"}, quotient, '0);
    checkOutput({tag, "_r"}, remainder, '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkIdleCleared("reset");
    reset = 1'b0;

    // Directed vectors, results accepted immediately.
    applyStimulus(32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
    applyStimulus(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
    applyStimulus(32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1);
    applyStimulus(32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678);
    applyStimulus(32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678);
    applyStimulus(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0);
    applyStimulus(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000);
    applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0);
    waitDrain(60);

    // Back-pressure: hold the result in DONE for 10 cycles.
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE);
    waitValid(50);
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_q", quotient, 32'd14);
      checkOutput("bp_r", remainder, 32'hFFFF_FFFE);
      checkOutput("bp_ready", W'(div_ready), W'(0));
      checkOutput("bp_valid", W'(out_valid), W'(1));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_ready", W'(div_ready), W'(1));
    checkOutput("bp_release_valid", W'(out_valid), W'(0));
    waitDrain(5);
    applyStimulus(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0);
    waitDrain(60);

    // Cancel at CALC step 15, then a request in the same cycle as cancel.
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    repeat (15) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    sb.delete();
    checkOutput("cancel_ready", W'(div_ready), W'(1));
    checkOutput("cancel_valid", W'(out_valid), W'(0));
    @(negedge clk);
    x = 32'd5;
    y = 32'd1;
    div_valid = 1'b1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    cancel = 1'b0;
    checkOutput("cancel_blocks_accept", W'(div_ready), W'(1));
    applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
    waitDrain(60);
    repeat (5) @(posedge clk);

    // Reset in the middle of CALC.
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checkIdleCleared("rst_calc");
    reset = 1'b0;
    sb.delete();

    // Reset while a result is held in DONE.
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    waitValid(50);
    checkOutput("done_hold_q", quotient, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checkIdleCleared("rst_done");
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;

    // Normal operation after reset.
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    waitDrain(60);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
